// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port general register file with a pending scoreboard.
//   clk, reset        : clock; synchronous active-high reset
//   rd_addr/rd_data   : NUM_RD combinational read ports with write forwarding
//   rd_pending        : addressed register still awaits its producer
//   wa_* / wb_*       : two write ports, B wins on an address collision
//   rsv_en/rsv_addr   : mark a register pending (decode-stage reservation)
//   busy_cnt          : number of pending registers
//   trace_*           : registered record of the writes committed last edge
//
// regfile_mp_sb_rd: one read port (forwarding mux + hazard flag).

module regfile_mp_sb_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              arr_pend,
  input  logic              wa_eff,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_eff,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              pending
);
  logic hit_a, hit_b;

  always_comb begin
    hit_a = wa_eff && (wa_addr == addr);
    hit_b = wb_eff && (wb_addr == addr);
    data  = arr_data;
    if ((ZERO_REG != 0) && (addr == '0)) data = '0;
    else if (hit_b)                      data = wb_data;
    else if (hit_a)                      data = wa_data;
    // A same-cycle write supplies the value, so the hazard is already resolved.
    pending = arr_pend && !(hit_a || hit_b);
  end
endmodule

module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wa_we,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_we,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [1:0]               trace_valid,
  output logic [2*ADDR_W-1:0]      trace_addr,
  output logic [2*DATA_W-1:0]      trace_data
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend, pend_nxt;
  logic                         wa_eff, wb_eff, wa_commit, rsv_eff;
  logic                         inc, dec_a, dec_b;
  logic [ADDR_W:0]              busy_nxt;

  always_comb begin
    wa_eff    = wa_we  && !((ZERO_REG != 0) && (wa_addr  == '0));
    wb_eff    = wb_we  && !((ZERO_REG != 0) && (wb_addr  == '0));
    rsv_eff   = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    // A colliding with B is dropped entirely; B's own clear covers that register.
    wa_commit = wa_eff && !(wb_eff && (wb_addr == wa_addr));

    for (int r = 0; r < DEPTH; r++) begin
      pend_nxt[r] = pend[r];
      if ((wa_commit && (wa_addr == ADDR_W'(r))) || (wb_eff && (wb_addr == ADDR_W'(r))))
        pend_nxt[r] = 1'b0;
      if (rsv_eff && (rsv_addr == ADDR_W'(r)))
        pend_nxt[r] = 1'b1;
    end

    // Incremental count: only rsv can set a bit, each committing port can clear
    // one. wa_commit guarantees the two write addresses differ.
    inc      = rsv_eff && !pend[rsv_addr];
    dec_a    = wa_commit && pend[wa_addr] && !(rsv_eff && (rsv_addr == wa_addr));
    dec_b    = wb_eff    && pend[wb_addr] && !(rsv_eff && (rsv_addr == wb_addr));
    busy_nxt = busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec_a) - (ADDR_W+1)'(dec_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '0;
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wa_commit) regs[wa_addr] <= wa_data;
      if (wb_eff)    regs[wb_addr] <= wb_data;
      pend     <= pend_nxt;
      busy_cnt <= busy_nxt;
    end
  end

  // Slices hold their last committed value while their valid bit is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= {wb_eff, wa_commit};
      if (wa_commit) begin
        trace_addr[0 +: ADDR_W] <= wa_addr;
        trace_data[0 +: DATA_W] <= wa_data;
      end
      if (wb_eff) begin
        trace_addr[ADDR_W +: ADDR_W] <= wb_addr;
        trace_data[DATA_W +: DATA_W] <= wb_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gen_rd
    regfile_mp_sb_rd #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .arr_data(regs[rd_addr[i*ADDR_W +: ADDR_W]]),
      .arr_pend(pend[rd_addr[i*ADDR_W +: ADDR_W]]),
      .wa_eff  (wa_eff),
      .wa_addr (wa_addr),
      .wa_data (wa_data),
      .wb_eff  (wb_eff),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data    (rd_data[i*DATA_W +: DATA_W]),
      .pending (rd_pending[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed plan plus random traffic, checked against
// a behavioural model through an expectation queue.
module tb_regfile_mp_sb;
  localparam int DW = 32, AW = 5, NR = 2, D = 32;

  logic              clk, reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_pending;
  logic              wa_we, wb_we, rsv_en;
  logic [AW-1:0]     wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0]     wa_data, wb_data;
  logic [AW:0]       busy_cnt;
  logic [1:0]        trace_valid;
  logic [2*AW-1:0]   trace_addr;
  logic [2*DW-1:0]   trace_data;

  regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_cnt(busy_cnt), .trace_valid(trace_valid),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { string tag; int sig; logic [63:0] val; } exp_t;
  exp_t q_comb[$], q_reg[$];
  int n_chk = 0, n_err = 0;
  logic [DW-1:0] m_regs [D];
  logic          m_pend [D];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_of(input int sig);
    case (sig)
      0: return 64'(trace_valid);
      1: return 64'(trace_addr[AW-1:0]);
      2: return 64'(trace_addr[2*AW-1:AW]);
      3: return 64'(trace_data[DW-1:0]);
      4: return 64'(trace_data[2*DW-1:DW]);
      5: return 64'(busy_cnt);
      default:
        if (sig >= 20) return 64'(rd_pending[sig-20]);
        else           return 64'(rd_data[(sig-10)*DW +: DW]);
    endcase
  endfunction

  task automatic push(inout exp_t q[$], input string tag, input int sig, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    q.push_back(e);
  endtask

  task automatic drain(inout exp_t q[$]);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs_of(e.sig), e.val);
    end
  endtask

  // One clock: predict reads for the current inputs, check them mid-cycle,
  // advance the model, check registered outputs just after the edge.
  task automatic cycle();
    logic ea, eb, ca, ha, hb;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int cnt;
    ea = wa_we && (wa_addr != 0);
    eb = wb_we && (wb_addr != 0);
    ca = ea && !(eb && (wb_addr == wa_addr));
    for (int i = 0; i < NR; i++) begin
      a  = rd_addr[i*AW +: AW];
      ha = ea && (wa_addr == a);
      hb = eb && (wb_addr == a);
      if (a == 0)  d = '0;
      else if (hb) d = wb_data;
      else if (ha) d = wa_data;
      else         d = m_regs[a];
      push(q_comb, $sformatf("rd_data%0d r%0d", i, a), 10+i, 64'(d));
      push(q_comb, $sformatf("rd_pending%0d r%0d", i, a), 20+i, 64'(m_pend[a] && !(ha || hb)));
    end
    @(negedge clk);
    drain(q_comb);
    if (reset) begin
      for (int r = 0; r < D; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
      push(q_reg, "trace_valid rst", 0, 64'(0));
      push(q_reg, "trace_addr rst", 1, 64'(0));
      push(q_reg, "trace_data rst", 4, 64'(0));
    end else begin
      if (ca) begin m_regs[wa_addr] = wa_data; m_pend[wa_addr] = 1'b0; end
      if (eb) begin m_regs[wb_addr] = wb_data; m_pend[wb_addr] = 1'b0; end
      if (rsv_en && (rsv_addr != 0)) m_pend[rsv_addr] = 1'b1;
      push(q_reg, "trace_valid", 0, 64'({eb, ca}));
      if (ca) begin
        push(q_reg, "trace_addr_a", 1, 64'(wa_addr));
        push(q_reg, "trace_data_a", 3, 64'(wa_data));
      end
      if (eb) begin
        push(q_reg, "trace_addr_b", 2, 64'(wb_addr));
        push(q_reg, "trace_data_b", 4, 64'(wb_data));
      end
    end
    cnt = 0;
    for (int r = 0; r < D; r++) cnt += int'(m_pend[r]);
    push(q_reg, "busy_cnt", 5, 64'(cnt));
    @(posedge clk); #1;
    drain(q_reg);
  endtask

  task automatic idle();
    wa_we = 0; wb_we = 0; rsv_en = 0; reset = 0;
  endtask

  initial begin
    reset = 1; rd_addr = '0; idle(); reset = 1;
    wa_addr = '0; wb_addr = '0; rsv_addr = '0; wa_data = '0; wb_data = '0;
    for (int r = 0; r < D; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
    @(posedge clk); #1;
    cycle();
    idle();
    chk("busy after reset", 64'(busy_cnt), 64'(0));
    chk("trace_valid after reset", 64'(trace_valid), 64'(0));
    for (int a = 0; a < D; a++) begin
      rd_addr = {AW'(a), AW'(D-1-a)};
      #1;
      chk($sformatf("reset read r%0d", a), 64'(rd_data), 64'(0));
      chk($sformatf("reset pend r%0d", a), 64'(rd_pending), 64'(0));
    end

    // Forwarded write on port A.
    wa_we = 1; wa_addr = 3; wa_data = 32'h1234; rd_addr = {AW'(0), AW'(3)};
    #1 chk("fwd r3", 64'(rd_data[DW-1:0]), 64'h1234);
    cycle();
    chk("trace r3 valid", 64'(trace_valid), 64'b01);
    chk("trace r3 addr", 64'(trace_addr[AW-1:0]), 64'd3);
    idle(); #1 chk("stored r3", 64'(rd_data[DW-1:0]), 64'h1234);
    cycle();

    // Collision: B wins.
    wa_we = 1; wa_addr = 5; wa_data = 32'hAAAA;
    wb_we = 1; wb_addr = 5; wb_data = 32'hBBBB; rd_addr = {AW'(5), AW'(5)};
    #1 chk("collide fwd r5", 64'(rd_data[DW-1:0]), 64'hBBBB);
    cycle();
    chk("collide trace", 64'(trace_valid), 64'b10);
    idle(); #1 chk("collide stored r5", 64'(rd_data[DW-1:0]), 64'hBBBB);
    cycle();

    // Zero register is inert.
    wa_we = 1; wa_addr = 0; wa_data = 32'hFFFF;
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF;
    rsv_en = 1; rsv_addr = 0; rd_addr = '0;
    #1 chk("r0 fwd", 64'(rd_data[DW-1:0]), 64'h0);
    cycle();
    chk("r0 trace", 64'(trace_valid), 64'b00);
    chk("r0 busy", 64'(busy_cnt), 64'(0));
    idle();

    // Reserve / reserve+write / write.
    rsv_en = 1; rsv_addr = 7; rd_addr = {AW'(7), AW'(7)};
    cycle();
    idle(); #1 chk("r7 pending", 64'(rd_pending[0]), 64'(1));
    chk("r7 busy1", 64'(busy_cnt), 64'(1));
    wb_we = 1; wb_addr = 7; wb_data = 32'h77; rsv_en = 1; rsv_addr = 7;
    #1 chk("r7 fwd", 64'(rd_data[DW-1:0]), 64'h77);
    chk("r7 pend resolved", 64'(rd_pending[0]), 64'(0));
    cycle();
    chk("r7 busy still 1", 64'(busy_cnt), 64'(1));
    idle(); #1 chk("r7 pending again", 64'(rd_pending[0]), 64'(1));
    wa_we = 1; wa_addr = 7; wa_data = 32'h78;
    cycle();
    chk("r7 busy0", 64'(busy_cnt), 64'(0));
    idle();

    // Reserve three, then reset overrides a write.
    for (int r = 1; r <= 3; r++) begin
      rsv_en = 1; rsv_addr = AW'(r);
      cycle();
    end
    idle();
    chk("busy3", 64'(busy_cnt), 64'(3));
    reset = 1; wb_we = 1; wb_addr = 1; wb_data = 32'hDEAD; rd_addr = {AW'(3), AW'(1)};
    cycle();
    chk("reset busy", 64'(busy_cnt), 64'(0));
    chk("reset trace", 64'(trace_valid), 64'(0));
    idle(); #1 chk("reset clears r1/r3", 64'(rd_data), 64'(0));
    cycle();

    // Random traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      wa_we    = $urandom_range(0, 1) == 1;
      wb_we    = $urandom_range(0, 2) == 0;
      rsv_en   = $urandom_range(0, 1) == 1;
      wa_addr  = AW'($urandom_range(0, 7));
      wb_addr  = AW'($urandom_range(0, 7));
      rsv_addr = AW'($urandom_range(0, (n % 4 == 0) ? 31 : 7));
      wa_data  = $urandom;
      wb_data  = $urandom;
      rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port general register file for the pipelined CPU.
- Generalises the single-write GRF to two write ports with fixed priority, NUM_RD forwarded read ports, and a per-register pending scoreboard for hazard detection.
- Also provides a registered write-trace stream to the bench, replacing in-RTL display.
- Sits between the decode (read/reserve) and writeback (commit) stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed forwarded read data.
- rd_pending  out  NUM_RD  1 = the addressed register awaits a producer, so its data is stale.
- wa_we  in  1  write port A enable (earlier-stage writer, lower priority).
- wa_addr  in  ADDR_W  port A address.
- wa_data  in  DATA_W  port A data.
- wb_we  in  1  write port B enable (higher priority).
- wb_addr  in  ADDR_W  port B address.
- wb_data  in  DATA_W  port B data.
- rsv_en  in  1  reserve: mark rsv_addr pending.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of pending registers.
- trace_valid  out  2  bit0 = port A committed, bit1 = port B committed, one cycle earlier.
- trace_addr  out  2*ADDR_W  committed addresses, port A in the low slice.
- trace_data  out  2*DATA_W  committed data, port A in the low slice.

Behaviour:
- Reset (sync): all registers <= 0, all pending bits <= 0, busy_cnt <= 0, trace_valid <= 0; trace_addr and trace_data <= 0.
- A write is effective when its enable is 1 and, if ZERO_REG, its address is nonzero.
- Writes commit at posedge.
- When A and B are both effective on the same address, B's data is stored and A's write is dropped entirely (no trace, no pending clear from A).
- Reads are combinational. Per read port i:
  - if ZERO_REG and addr == 0, data = 0;
  - else if B is effective to addr, data = wb_data;
  - else if A is effective to addr, data = wa_data;
  - else the array value.
- Scoreboard, at each posedge:
  - pending[r] is cleared if any effective write targets r.
  - pending[r] is then set if rsv_en and rsv_addr == r (and r != 0 under ZERO_REG).
  - Reserve and write to the same register on the same edge: the register ends pending (new producer wins).
  - Reserving an already-pending register keeps it pending; busy_cnt does not change.
- rd_pending[i] = pending[addr_i] AND NOT (an effective write targets addr_i this cycle). Same-cycle forwarding resolves the hazard.
- Same-cycle rsv_en does not affect rd_pending until the next cycle.
- busy_cnt is a registered count equal to popcount(pending) after each edge. It is updated incrementally (+1 per newly set bit, -1 per newly cleared bit), never by full recount. Max value 2**ADDR_W - ZERO_REG, with no wrap.
- Writes to non-pending registers are legal and leave the scoreboard unchanged.
- Trace, registered, latency 1:
  - trace_valid[0] = A effective and not overridden by B.
  - trace_valid[1] = B effective.
  - addr/data slices capture the committed values.
  - Valid bits are a pulse per write.
- Reset asserted mid-operation overrides all writes, reserves and trace on that edge.

Test Plan:
- Reset, then read all addresses on every port -> all 0, rd_pending = 0, busy_cnt = 0, trace_valid = 0.
- wa_we=1, wa_addr=3, wa_data=0x1234; rd_addr port0=3 same cycle -> rd_data0=0x1234 (forwarded). Next cycle: array holds 0x1234, trace_valid=01, trace_addr[4:0]=3.
- Same edge: A writes r5=0xAAAA and B writes r5=0xBBBB -> read shows 0xBBBB before and after the edge; trace_valid=10 only.
- Write r0=0xFFFF on both ports, and rsv_en on r0 -> r0 reads 0, no trace, busy_cnt stays 0.
- Reserve r7 -> next cycle rd_pending=1 and busy_cnt=1. Then wb writes r7=0x77 while rsv_en on r7 -> data forwarded, r7 still pending, busy_cnt=1. Then wa writes r7 alone -> busy_cnt=0.
- Reserve r1, r2, r3 on consecutive cycles, then assert reset while wb writes r1 -> all regs 0, busy_cnt=0, trace_valid=0 after the edge.
